serializer4: RTL and testbench

- Parallel-to-serial transmitter: captures a 4-bit word (same D/ENABLE register style as the DFlipFlop4 block) and shifts it out one bit per enabled clock.
- Appends an optional even-parity bit to each frame.
- Forms the transmit end of a serial link; the matching deserializer rebuilds the word into a DFlipFlop4-style register.
- Valid/ready handshake on the parallel side; valid/last framing on the serial side.

---
 rtl/serializer4.sv | 115 +++++++++++
 tb/tb_serializer4.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer4.sv
// Parallel-to-serial transmitter: latches a word, shifts it out one bit per
// enabled clock with valid/last framing and an optional trailing even-parity bit.
module serializer4 #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    output logic             READY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             SLAST,
    output logic             BUSY
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             par;

    // The bit currently on the line always sits at the head of the shift register.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        shreg_nxt = advance(shreg);
        cnt_nxt   = cnt + CNT_W'(1);
    end

    assign READY = (state == IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            par    <= 1'b0;
            SOUT   <= 1'b0;
            SVALID <= 1'b0;
            SLAST  <= 1'b0;
            BUSY   <= 1'b0;
        end else if (ENABLE) begin
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        shreg  <= D;
                        par    <= ^D;
                        cnt    <= '0;
                        SOUT   <= head(D);
                        SVALID <= 1'b1;
                        SLAST  <= 1'b0;
                        BUSY   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_IDX) begin
                        if (PARITY_EN) begin
                            SOUT  <= par;
                            SLAST <= 1'b1;
                            state <= PARITY;
                        end else begin
                            shreg  <= '0;
                            cnt    <= '0;
                            SOUT   <= 1'b0;
                            SVALID <= 1'b0;
                            SLAST  <= 1'b0;
                            BUSY   <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        // Without parity the last data bit itself carries SLAST.
                        cnt   <= cnt_nxt;
                        shreg <= shreg_nxt;
                        SOUT  <= head(shreg_nxt);
                        SLAST <= !PARITY_EN && (cnt_nxt == LAST_IDX);
                    end
                end
                PARITY: begin
                    shreg  <= '0;
                    cnt    <= '0;
                    SOUT   <= 1'b0;
                    SVALID <= 1'b0;
                    SLAST  <= 1'b0;
                    BUSY   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer4.sv
// Bench for serializer4: three configurations share stimulus; a frame-level
// reference model plus a table of hand-derived bit streams.
module tb_serializer4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] D = 4'd0;
    logic [2:0] rdy, so, sv, sl, bz;

    always #5 CLK = ~CLK;

    serializer4 #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u0 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .D(D), .LOAD(LOAD),
        .READY(rdy[0]), .SOUT(so[0]), .SVALID(sv[0]), .SLAST(sl[0]), .BUSY(bz[0]));
    serializer4 #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u1 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .D(D), .LOAD(LOAD),
        .READY(rdy[1]), .SOUT(so[1]), .SVALID(sv[1]), .SLAST(sl[1]), .BUSY(bz[1]));
    serializer4 #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u2 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .D(D), .LOAD(LOAD),
        .READY(rdy[2]), .SOUT(so[2]), .SVALID(sv[2]), .SLAST(sl[2]), .BUSY(bz[2]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each instance either idles (pos<0) or shows frame bit pos.
    bit cfg_msb[3] = '{1'b1, 1'b0, 1'b1};
    bit cfg_pen[3] = '{1'b1, 1'b1, 1'b0};
    int pos[3]     = '{-1, -1, -1};
    int flen[3]    = '{5, 5, 4};
    bit fb[3][5];

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pos[i] = -1;
    endfunction

    function automatic void model_edge();
        if (!RESET) begin
            model_clear();
        end else if (ENABLE) begin
            for (int i = 0; i < 3; i++) begin
                if (pos[i] < 0) begin
                    if (LOAD) begin
                        flen[i] = 4 + (cfg_pen[i] ? 1 : 0);
                        for (int k = 0; k < 4; k++)
                            fb[i][k] = cfg_msb[i] ? D[3-k] : D[k];
                        fb[i][4] = ^D;
                        pos[i] = 0;
                    end
                end else if (pos[i] == flen[i] - 1) begin
                    pos[i] = -1;
                end else begin
                    pos[i]++;
                end
            end
        end
    endfunction

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            logic act;
            act = (pos[i] >= 0);
            chk($sformatf("u%0d ready", i),  rdy[i], !act);
            chk($sformatf("u%0d svalid", i), sv[i],  act);
            chk($sformatf("u%0d busy", i),   bz[i],  act);
            chk($sformatf("u%0d sout", i),   so[i],  act ? fb[i][pos[i]] : 1'b0);
            chk($sformatf("u%0d slast", i),  sl[i],  act && (pos[i] == flen[i] - 1));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic [3:0] d;
        logic [4:0] s0;  // MSB first + parity, first bit in [4]
        logic [4:0] s1;  // LSB first + parity
        logic [3:0] s2;  // MSB first, no parity, first bit in [3]
    } vec_t;
    vec_t vt[8];

    task automatic run_frame(input vec_t v);
        D = v.d; LOAD = 1'b1; ENABLE = 1'b1;
        tick();
        LOAD = 1'b0;
        D = 4'($urandom);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k < 5) begin
                chk("tbl u0 sout",  so[0], v.s0[4-k]);
                chk("tbl u0 slast", sl[0], k == 4);
                chk("tbl u1 sout",  so[1], v.s1[4-k]);
                chk("tbl u1 slast", sl[1], k == 4);
            end else begin
                chk("tbl u0 svalid end", sv[0], 1'b0);
                chk("tbl u0 ready end",  rdy[0], 1'b1);
            end
            if (k < 4) begin
                chk("tbl u2 sout",  so[2], v.s2[3-k]);
                chk("tbl u2 slast", sl[2], k == 3);
            end else if (k == 4) begin
                chk("tbl u2 svalid end", sv[2], 1'b0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] got;
        int n, ls;

        vt[0] = '{4'b1011, 5'b10111, 5'b11011, 4'b1011};
        vt[1] = '{4'b0001, 5'b00011, 5'b10001, 4'b0001};
        vt[2] = '{4'b0000, 5'b00000, 5'b00000, 4'b0000};
        vt[3] = '{4'b1001, 5'b10010, 5'b10010, 4'b1001};
        vt[4] = '{4'b1100, 5'b11000, 5'b00110, 4'b1100};
        vt[5] = '{4'b0110, 5'b01100, 5'b01100, 4'b0110};
        vt[6] = '{4'b1111, 5'b11110, 5'b11110, 4'b1111};
        vt[7] = '{4'b0111, 5'b01111, 5'b11101, 4'b0111};

        // Reset state
        #2 RESET = 1'b0;
        #1;
        model_clear();
        chk("reset ready",  rdy, 3'b111);
        chk("reset svalid", sv,  3'b000);
        chk("reset slast",  sl,  3'b000);
        chk("reset busy",   bz,  3'b000);
        chk("reset sout",   so,  3'b000);
        tick();
        tick();
        RESET = 1'b1;

        // LOAD with ENABLE low in IDLE starts nothing
        ENABLE = 1'b0; LOAD = 1'b1; D = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gated load svalid", sv, 3'b000);
            chk("gated load ready",  rdy, 3'b111);
        end
        LOAD = 1'b0; ENABLE = 1'b1;
        tick();
        chk("gated load after", sv, 3'b000);

        for (int i = 0; i < 8; i++) run_frame(vt[i]);

        // ENABLE low for 3 cycles after the 2nd bit
        D = 4'b1100; LOAD = 1'b1; ENABLE = 1'b1;
        tick();
        LOAD = 1'b0;
        got[4] = so[0];
        tick();
        got[3] = so[0];
        ENABLE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze sout",   so[0], 1'b1);
            chk("freeze svalid", sv[0], 1'b1);
        end
        ENABLE = 1'b1;
        for (int k = 2; k < 5; k++) begin
            tick();
            got[4-k] = so[0];
        end
        chk("freeze stream", got, 5'b11000);
        tick();
        chk("freeze end svalid", sv[0], 1'b0);
        tick();

        // Asynchronous reset during the 3rd bit
        D = 4'b1100; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        tick();
        tick();
        chk("pre-reset svalid", sv[0], 1'b1);
        #2 RESET = 1'b0;
        #1;
        model_clear();
        chk("async reset svalid", sv,  3'b000);
        chk("async reset slast",  sl,  3'b000);
        chk("async reset busy",   bz,  3'b000);
        chk("async reset ready",  rdy, 3'b111);
        #2 RESET = 1'b1;
        run_frame(vt[5]);

        // LOAD held high, D stepping 0..15
        LOAD = 1'b1; ENABLE = 1'b1;
        for (int w = 0; w < 16; w++) begin
            D = 4'(w);
            n = 0;
            while (rdy[0] !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("step ready before accept", rdy[0], 1'b1);
            tick();
            n = 0; ls = 0;
            while (rdy[0] !== 1'b1 && n < 20) begin
                n++;
                if (sl[0]) ls++;
                tick();
            end
            chk("step ready low cycles", n, 5);
            chk("step slast count", ls, 1);
        end
        LOAD = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            ENABLE = ($urandom_range(0, 3) != 0);
            LOAD   = $urandom_range(0, 1) == 1;
            D      = 4'($urandom);
            tick();
            if ($urandom_range(0, 59) == 0) begin
                #2 RESET = 1'b0;
                #1;
                model_clear();
                model_check();
                #2 RESET = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
